// File: rtl/i_type_pkg.sv
// Shared constants for the LEGv8 I-format encode/decode paths: op codes,
// opcode tails, loader FSM states and the immediate range limit.
package i_type_pkg;

    localparam logic [2:0] OP_ADDI  = 3'b000;
    localparam logic [2:0] OP_ADDIS = 3'b001;
    localparam logic [2:0] OP_SUBI  = 3'b010;
    localparam logic [2:0] OP_SUBIS = 3'b011;
    localparam logic [2:0] OP_ANDI  = 3'b100;
    localparam logic [2:0] OP_ORRI  = 3'b101;
    localparam logic [2:0] OP_EORI  = 3'b110;
    localparam logic [2:0] OP_ANDIS = 3'b111;

    // Low seven opcode bits that follow op[1:0] in instr[28:22].
    localparam logic [6:0] TAIL_ARITH = 7'b1000100;
    localparam logic [6:0] TAIL_LOGIC = 7'b1001000;

    localparam int unsigned IMM_W   = 12;
    localparam int unsigned IMM_MAX = 4095;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    function automatic logic imm_in_range(input logic [63:0] imm);
        return imm <= 64'(IMM_MAX);
    endfunction

endpackage

// File: rtl/i_type_encoder_if.sv
// Request handshake and instruction-RAM write port between the loader,
// the encoder and the instruction memory.
interface i_type_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rn;
    logic [63:0]       req_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    modport master (
        output req_valid, req_op, req_rd, req_rn, req_imm,
        input  req_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rn, req_imm,
        output req_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/i_word_pack.sv
// Packs one I-type ALU request into its 32-bit LEGv8 instruction word.
module i_word_pack
    import i_type_pkg::*;
(
    input  logic [2:0]       op_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rn_i,
    input  logic [IMM_W-1:0] imm12_i,
    output logic [31:0]      word_o
);
    always_comb begin
        word_o = {1'b1, op_i[1:0], (op_i[2] ? TAIL_LOGIC : TAIL_ARITH),
                  imm12_i, rn_i, rd_i};
    end
endmodule

// File: rtl/i_type_encoder.sv
// Program-load encoder: accepts I-type requests, packs them and writes them
// to consecutive instruction-memory words, one write per two cycles at most.
module i_type_encoder
    import i_type_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    i_type_encoder_if.slave   bus,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              done,
    output logic              imm_err
);
    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [31:0]       data_q;
    logic [31:0]       word;
    logic              we_q;
    logic              full_q;
    logic              done_q;
    logic              err_q;

    i_word_pack u_pack (
        .op_i    (bus.req_op),
        .rd_i    (bus.req_rd),
        .rn_i    (bus.req_rn),
        .imm12_i (bus.req_imm[IMM_W-1:0]),
        .word_o  (word)
    );

    always_comb begin
        addr_d  = addr_q + ADDR_W'(4);
        count_d = count_q + CNT_W'(1);
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            // Start re-arms from any state; in WRITE the strobe has already
            // been presented this cycle, so the restart lands on its closing edge.
            if (start) begin
                state_q <= ST_RUN;
                addr_q  <= {base_addr[ADDR_W-1:2], 2'b00};
                count_q <= '0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: ;
                    ST_RUN: begin
                        if (stop) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else if (bus.req_valid) begin
                            if (imm_in_range(bus.req_imm)) begin
                                data_q  <= word;
                                we_q    <= 1'b1;
                                state_q <= ST_WRITE;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        if (count_d == CNT_W'(DEPTH)) begin
                            state_q <= ST_FULL;
                            full_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_FULL: begin
                        if (stop) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready = (state_q == ST_RUN);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_data  = data_q;
    assign count         = count_q;
    assign full          = full_q;
    assign done          = done_q;
    assign imm_err       = err_q;

endmodule

// File: tb/tb_i_type_encoder.sv
// Directed bench for i_type_encoder: expected RAM writes are queued when a
// request is sent and retired by a write monitor on the falling clock edge.
module tb_i_type_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              done;
    logic              imm_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    wr_t               exp_q[$];
    logic [ADDR_W-1:0] exp_addr;

    i_type_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    i_type_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .bus       (bus),
        .count     (count),
        .full      (full),
        .done      (done),
        .imm_err   (imm_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rn, input logic [11:0] imm);
        logic [6:0] tail;
        tail = op[2] ? 7'h48 : 7'h44;
        return {1'b1, op[1:0], tail, imm, rn, rd};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ready"},  64'(bus.req_ready), 64'd0);
        check({pfx, "_we"},     64'(bus.mem_we),    64'd0);
        check({pfx, "_full"},   64'(full),          64'd0);
        check({pfx, "_done"},   64'(done),          64'd0);
        check({pfx, "_err"},    64'(imm_err),       64'd0);
        check({pfx, "_count"},  64'(count),         64'd0);
        check({pfx, "_addr"},   64'(bus.mem_addr),  64'd0);
        check({pfx, "_data"},   64'(bus.mem_data),  64'd0);
    endtask

    task automatic arm(input logic [ADDR_W-1:0] base);
        base_addr = base;
        start     = 1'b1;
        step();
        start     = 1'b0;
        exp_addr  = base & ~ADDR_W'(3);
    endtask

    // Returns #1 after the accepting edge, i.e. inside the WRITE cycle when
    // the request is in range.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [63:0] imm, input logic [31:0] exp_word, input logic writes);
        int waited;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rd    = rd;
        bus.req_rn    = rn;
        bus.req_imm   = imm;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 64'(bus.req_ready), 64'd1);
        end else begin
            if (writes) begin
                exp_q.push_back('{addr: exp_addr, data: exp_word});
                exp_addr = exp_addr + ADDR_W'(4);
            end
            step();
        end
        bus.req_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bus.mem_addr), 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
                check("wr_data", 64'(bus.mem_data), 64'(w.data));
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rd = '0;
        bus.req_rn = '0; bus.req_imm = '0;
        exp_addr = '0;
        step(); step();
        reset = 1'b0;
        check_reset_vals("rst");

        arm(8'h10);
        check("armed_ready", 64'(bus.req_ready), 64'd1);
        check("armed_addr",  64'(bus.mem_addr),  64'h10);

        send(3'b000, 5'd1, 5'd2, 64'd5, 32'h9100_1441, 1'b1);
        check("w1_we",    64'(bus.mem_we),    64'd1);
        check("w1_ready", 64'(bus.req_ready), 64'd0);
        step();
        check("w1_count", 64'(count), 64'd1);

        send(3'b101, 5'd3, 5'd4, 64'hFF, 32'hB203_FC83, 1'b1);
        check("w2_ready", 64'(bus.req_ready), 64'd0);
        step();
        check("w2_count", 64'(count), 64'd2);

        send(3'b010, 5'd5, 5'd6, 64'd4096, 32'h0, 1'b0);
        check("bad_we",    64'(bus.mem_we),    64'd0);
        check("bad_err",   64'(imm_err),       64'd1);
        check("bad_ready", 64'(bus.req_ready), 64'd1);
        step(); step();
        check("err_sticky", 64'(imm_err), 64'd1);
        check("bad_count",  64'(count),   64'd2);

        send(3'b011, 5'd7, 5'd8, 64'd4095, model(3'b011, 5'd7, 5'd8, 12'hFFF), 1'b1);
        step();
        check("w3_count", 64'(count), 64'd3);

        send(3'b110, 5'd31, 5'd0, 64'h800, model(3'b110, 5'd31, 5'd0, 12'h800), 1'b1);
        step();
        check("w4_count", 64'(count),         64'd4);
        check("w4_full",  64'(full),          64'd1);
        check("w4_ready", 64'(bus.req_ready), 64'd0);

        bus.req_valid = 1'b1; bus.req_op = 3'b111; bus.req_imm = 64'd1;
        repeat (5) step();
        check("full_ready", 64'(bus.req_ready), 64'd0);
        check("full_count", 64'(count),         64'd4);
        bus.req_valid = 1'b0;

        arm(8'h40);
        check("rearm_count", 64'(count),         64'd0);
        check("rearm_full",  64'(full),          64'd0);
        check("rearm_ready", 64'(bus.req_ready), 64'd1);
        check("rearm_err",   64'(imm_err),       64'd0);
        check("rearm_addr",  64'(bus.mem_addr),  64'h40);

        bus.req_valid = 1'b1; bus.req_imm = 64'd3;
        stop = 1'b1;
        step();
        stop = 1'b0; bus.req_valid = 1'b0;
        check("stop_done",  64'(done),          64'd1);
        check("stop_ready", 64'(bus.req_ready), 64'd0);
        check("stop_we",    64'(bus.mem_we),    64'd0);
        step();
        check("done_pulse", 64'(done),  64'd0);
        check("stop_count", 64'(count), 64'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("idle_stop_done", 64'(done), 64'd0);

        arm(8'h20);
        send(3'b001, 5'd9, 5'd10, 64'd77, model(3'b001, 5'd9, 5'd10, 12'd77), 1'b1);
        check("abort_we", 64'(bus.mem_we), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("abort");

        arm(8'hFC);
        send(3'b100, 5'd11, 5'd12, 64'd1, model(3'b100, 5'd11, 5'd12, 12'd1), 1'b1);
        step();
        send(3'b111, 5'd13, 5'd14, 64'd2, model(3'b111, 5'd13, 5'd14, 12'd2), 1'b1);
        step();
        check("wrap_count", 64'(count),        64'd2);
        check("wrap_addr",  64'(bus.mem_addr), 64'h04);

        repeat (3) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
